// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide engine.
//   - funct3 encodings of the eight M-extension operations
//   - M-extension funct7 value used by the decoder to raise start
//   - FSM state encoding shared by the engine and anything that probes it
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result selection for the multiply/divide engine.
// Ports:
//   op      - latched funct3 of the running operation
//   sign_a  - rs1 was negative and treated as signed
//   sign_b  - rs2 was negative and treated as signed
//   acc     - unsigned magnitude accumulator: {hi, lo} product, or
//             {remainder, quotient} for divides
//   res     - corrected XLEN-bit result for the selected half/remainder
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   res
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    always_comb begin
        // Product and quotient take the sign of a^b; remainder follows the dividend.
        prod = (sign_a ^ sign_b) ? -acc : acc;
        quot = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res  = '0;
        if (!op[2]) begin
            res = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            res = op[1] ? rem : quot;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine for the EX stage (radix-2, one bit
// per cycle, one operation at a time).
// Ports:
//   clk, rstn      - pipeline clock, asynchronous active-low reset
//   start          - EX holds an M-extension instruction this cycle
//   op             - funct3 (MUL..REMU)
//   sr1, sr2       - forwarded rs1/rs2 values
//   flush          - EX instruction squashed; aborts the operation
//   stall          - combinational hold request to the hazard unit
//   done           - one-cycle pulse, result valid
//   result         - registered result, held until the next accepted start
// Handshake: an operation is accepted when start=1, flush=0 in IDLE. stall
// stays high from the accept cycle through CALC, so the upstream stages keep
// start/op/sr1/sr2 stable; done rises in FIN with stall low, letting EX/MEM
// capture result in that cycle and ID/EX advance (start drops or a new op
// appears in the following cycle, which is accepted back-to-back).
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] sr1,
    input  logic [XLEN-1:0] sr2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_t     state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic [2:0]        op_q;
    logic              sign_a_q, sign_b_q;
    logic [XLEN-1:0]   opnd_q;          // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_step;
    logic [XLEN-1:0]   result_q, result_prev_q;
    logic [XLEN-1:0]   fix_res, special_res;

    logic              accept, last_step;
    logic              signed_a, signed_b, sign_a, sign_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   div_rem;
    logic              div_ge;

    // ---------------- operand decode at accept ----------------
    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (op)
            OP_MULH:   begin signed_a = 1'b1; signed_b = 1'b1; end
            OP_MULHSU: begin signed_a = 1'b1; signed_b = 1'b0; end
            OP_DIV:    begin signed_a = 1'b1; signed_b = 1'b1; end
            OP_REM:    begin signed_a = 1'b1; signed_b = 1'b1; end
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: begin
                signed_a = 1'b0;
                signed_b = 1'b0;
            end
            default: ;
        endcase
        sign_a = signed_a & sr1[XLEN-1];
        sign_b = signed_b & sr2[XLEN-1];
        // Negating the most negative value yields the same bit pattern,
        // which read as unsigned is exactly its magnitude.
        mag_a  = sign_a ? -sr1 : sr1;
        mag_b  = sign_b ? -sr2 : sr2;

        div_zero = op[2] && (sr2 == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                   (sr1 == {1'b1, {(XLEN-1){1'b0}}}) && (sr2 == '1);
        special  = div_zero | div_ovf;
        if (op[1]) begin
            special_res = div_zero ? sr1 : '0;
        end else begin
            special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    accept  = 1'b1;
                    state_d = special ? FIN : CALC;
                end
            end
            CALC: begin
                if (count_q == CNT_W'(1)) begin
                    last_step = 1'b1;
                    state_d   = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d   = IDLE;
            last_step = 1'b0;
        end
    end

    // ---------------- one iteration ----------------
    always_comb begin
        // Multiply: add multiplicand to the high half when the current
        // multiplier bit (acc LSB) is set, then shift the whole thing right.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: shift left, trial-subtract the divisor from the widened
        // partial remainder; the kept difference always fits XLEN bits.
        div_ge  = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opnd_q};
        div_rem = acc_q[2*XLEN-2:XLEN-1] - opnd_q;
        if (op_q[2]) begin
            acc_step = div_ge ? {div_rem, acc_q[XLEN-2:0], 1'b1}
                              : {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // The corrected result is formed from the final iteration's value so that
    // it is already registered in the FIN cycle when done is high.
    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op     (op_q),
        .sign_a (sign_a_q),
        .sign_b (sign_b_q),
        .acc    (acc_step),
        .res    (fix_res)
    );

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q       <= '0;
            op_q          <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            opnd_q        <= '0;
            acc_q         <= '0;
            result_q      <= '0;
            result_prev_q <= '0;
        end else begin
            if (accept) begin
                op_q     <= op;
                sign_a_q <= sign_a;
                sign_b_q <= sign_b;
                count_q  <= CNT_W'(XLEN);
                if (op[2]) begin
                    opnd_q <= mag_b;
                    acc_q  <= {{XLEN{1'b0}}, mag_a};
                end else begin
                    opnd_q <= mag_a;
                    acc_q  <= {{XLEN{1'b0}}, mag_b};
                end
                if (special) begin
                    result_prev_q <= result_q;
                    result_q      <= special_res;
                end
            end else if (state_q == CALC && !flush) begin
                acc_q   <= acc_step;
                count_q <= count_q - CNT_W'(1);
            end
            if (last_step) begin
                result_prev_q <= result_q;
                result_q      <= fix_res;
            end
            // A squash in FIN discards the just-loaded value.
            if (state_q == FIN && flush) begin
                result_q <= result_prev_q;
            end
        end
    end

    assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC);
    assign done   = (state_q == FIN) && !flush;
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] sr1;
    logic [31:0] sr2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int vectors     = 0;
    int miscompares = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .sr1    (sr1),
        .sr2    (sr2),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic ref_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return (o[2] && b == 32'd0) ||
               ((o == 3'b100 || o == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] w;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        w  = '0;
        case (o)
            3'b000: begin w = ua * ub; return w[31:0];  end
            3'b001: begin w = sa * sb; return w[63:32]; end
            3'b010: begin w = sa * ub; return w[63:32]; end
            3'b011: begin w = ua * ub; return w[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                w = sa / sb; return w[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                w = sa % sb; return w[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // ---------------- transaction-level timing model ----------------
    bit          m_busy;
    int          m_age;     // cycles since accept
    int          m_lat;     // cycle in which done is due
    logic [31:0] m_result, m_old, m_pend;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy   <= 1'b0;
            m_age    <= 0;
            m_lat    <= 0;
            m_result <= '0;
            m_old    <= '0;
            m_pend   <= '0;
        end else if (!m_busy) begin
            if (start && !flush) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_lat  <= ref_special(op, sr1, sr2) ? 1 : 33;
                m_pend <= ref_result(op, sr1, sr2);
                if (ref_special(op, sr1, sr2)) begin
                    m_old    <= m_result;
                    m_result <= ref_result(op, sr1, sr2);
                end
            end
        end else if (flush) begin
            m_busy <= 1'b0;
            if (m_age == m_lat) m_result <= m_old;
        end else if (m_age == m_lat) begin
            m_busy <= 1'b0;
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == m_lat) begin
                m_old    <= m_result;
                m_result <= m_pend;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic exp_stall, exp_done;
        exp_stall = (!m_busy && start && !flush) || (m_busy && m_age < m_lat);
        exp_done  = m_busy && (m_age == m_lat) && !flush;
        vectors++;
        if (stall !== exp_stall || done !== exp_done || result !== m_result) begin
            miscompares++;
            $display("FAIL cycle t=%0t stall=%b want %b done=%b want %b result=%h want %h",
                     $time, stall, exp_stall, done, exp_done, result, m_result);
        end
    end

    // ---------------- driver / check helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents an op from the current cycle (cycle 0) and holds it until done.
    // flush_cyc >= 0 squashes it in that cycle. Returns the done cycle or -1.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int flush_cyc, output int done_cyc);
        logic got;
        done_cyc = -1;
        start = 1'b1;
        op    = o;
        sr1   = a;
        sr2   = b;
        for (int c = 0; c < 60; c++) begin
            flush = (c == flush_cyc);
            @(negedge clk);
            got = done;
            @(posedge clk);
            #1;
            flush = 1'b0;
            if (got) begin
                done_cyc = c;
                return;
            end
            if (c == flush_cyc) begin
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        vectors++;
        miscompares++;
        $display("FAIL timeout op=%0d no done within 60 cycles", o);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int dc, fc, ndone;
        logic [2:0]  o;
        logic [31:0] a, b;

        rstn  = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        sr1   = '0;
        sr2   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        rstn = 1'b1;
        idle(2);

        // Multiply family
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, -1, dc);
        check("mul_done_cycle", 32'(dc), 32'd33);
        check("mul_7x-3", result, 32'hFFFF_FFEB);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, dc);
        check("mulhu", result, 32'hFFFF_FFFE);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, dc);
        check("mulh", result, 32'h0000_0000);
        do_op(3'b010, 32'hFFFF_FFFF, 32'd2, -1, dc);
        check("mulhsu", result, 32'hFFFF_FFFF);

        // Divide family
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, -1, dc);
        check("div_done_cycle", 32'(dc), 32'd33);
        check("div_-7/2", result, 32'hFFFF_FFFD);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, -1, dc);
        check("rem_-7/2", result, 32'hFFFF_FFFF);
        do_op(3'b101, 32'd100, 32'd7, -1, dc);
        check("divu_100/7", result, 32'd14);
        do_op(3'b111, 32'd100, 32'd7, -1, dc);
        check("remu_done_cycle", 32'(dc), 32'd33);
        check("remu_100/7", result, 32'd2);

        // Special cases
        do_op(3'b101, 32'd5, 32'd0, -1, dc);
        check("divu_by0_cycle", 32'(dc), 32'd1);
        check("divu_by0", result, 32'hFFFF_FFFF);
        do_op(3'b110, 32'd5, 32'd0, -1, dc);
        check("rem_by0", result, 32'd5);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, -1, dc);
        check("div_ovf_cycle", 32'(dc), 32'd1);
        check("div_ovf", result, 32'h8000_0000);
        idle(2);

        // Flush in cycle 10 of a divide
        do_op(3'b100, 32'd1000, 32'd3, 10, dc);
        check("flush_no_done", 32'(dc), 32'hFFFF_FFFF);
        @(negedge clk);
        check("flush_stall_low", {31'd0, stall}, 32'd0);
        check("flush_keep_result", result, 32'h8000_0000);
        @(posedge clk);
        #1;
        do_op(3'b000, 32'd3, 32'd4, -1, dc);
        check("mul_after_flush_cycle", 32'(dc), 32'd33);
        check("mul_3x4", result, 32'd12);

        // flush dominates start in IDLE
        do_op(3'b000, 32'd5, 32'd5, 0, dc);
        check("start_flush_ignored", 32'(dc), 32'hFFFF_FFFF);
        check("start_flush_result", result, 32'd12);
        idle(1);

        // Randomized operations, some back-to-back, some squashed
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if (!ref_special(o, a, b) && $urandom_range(0, 7) == 0) fc = $urandom_range(1, 32);
            else if ($urandom_range(0, 15) == 0) fc = 0;
            else fc = -1;
            do_op(o, a, b, fc, dc);
            if (fc >= 0) check("rand_flush_no_done", 32'(dc), 32'hFFFF_FFFF);
            else check("rand_done_cycle", 32'(dc), ref_special(o, a, b) ? 32'd1 : 32'd33);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
        end
        idle(2);

        // Asynchronous reset in cycle 15 of a multiply
        do_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, -1, dc);
        start = 1'b1;
        op    = 3'b000;
        sr1   = 32'd11;
        sr2   = 32'd13;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        #1;
        rstn  = 1'b0;
        start = 1'b0;
        #1;
        check("areset_stall", {31'd0, stall}, 32'd0);
        check("areset_done", {31'd0, done}, 32'd0);
        check("areset_result", result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_done_after_reset", 32'(ndone), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
